// File: rtl/expr_sequencer.sv
// expr_sequencer: reorders an infix token stream (+, *, parentheses, operands)
// into postfix opcodes for a stack-based ALU using an internal operator stack,
// one ALU opcode per cycle, and captures the ALU top-of-stack on '='.
module expr_sequencer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned STACK_SIZE = 64,
   parameter int unsigned OP_DEPTH   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  tok_valid,
   output logic                  tok_ready,
   input  logic [2:0]            tok_type,
   input  logic [DATA_WIDTH-1:0] tok_data,
   output logic [2:0]            alu_opcode,
   output logic [DATA_WIDTH-1:0] alu_data,
   input  logic [DATA_WIDTH-1:0] alu_result,
   input  logic                  alu_overflow,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  result_valid,
   output logic                  syntax_err,
   output logic                  depth_err,
   output logic                  overflow_err,
   output logic                  busy
);

   localparam int unsigned SP_W  = $clog2(OP_DEPTH + 1);
   localparam int unsigned IDX_W = (OP_DEPTH > 1) ? $clog2(OP_DEPTH) : 1;
   localparam int unsigned OCC_W = $clog2(STACK_SIZE + 1);

   localparam logic [SP_W-1:0]  SP_FULL  = SP_W'(OP_DEPTH);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STACK_SIZE);

   typedef enum logic [1:0] {
      S_ACCEPT  = 2'b00,
      S_DRAIN   = 2'b01,
      S_CAPTURE = 2'b10,
      S_ERR     = 2'b11
   } state_e;

   typedef enum logic [2:0] {
      TOK_ADD  = 3'b000,
      TOK_MUL  = 3'b001,
      TOK_LPAR = 3'b010,
      TOK_RPAR = 3'b011,
      TOK_NUM  = 3'b100,
      TOK_EQ   = 3'b101,
      TOK_CLR  = 3'b110,
      TOK_RSV  = 3'b111
   } tok_e;

   typedef enum logic [2:0] {
      OPC_NOP  = 3'b000,
      OPC_CLR  = 3'b001,
      OPC_ADD  = 3'b100,
      OPC_MUL  = 3'b101,
      OPC_PUSH = 3'b110
   } opc_e;

   // Operator-stack entry encoding
   typedef enum logic [1:0] {
      ST_ADD  = 2'b00,
      ST_MUL  = 2'b01,
      ST_LPAR = 2'b10
   } stk_e;

   state_e                state_q, state_d;
   tok_e                  pend_q, pend_d;
   opc_e                  opc_q, opc_d;
   logic                  expect_q, expect_d;
   logic [SP_W-1:0]       sp_q, sp_d;
   logic [OCC_W-1:0]      occ_q, occ_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] result_q, result_d;
   logic                  syn_q, syn_d;
   logic                  dep_q, dep_d;
   logic                  ovf_q, ovf_d;

   stk_e                  opstk_q [OP_DEPTH];
   logic                  push_en;
   stk_e                  push_val;
   logic [IDX_W-1:0]      wr_idx;
   logic [IDX_W-1:0]      top_idx;
   logic                  top_valid;
   stk_e                  top_op;
   tok_e                  tok;
   logic                  accept;

   assign tok       = tok_e'(tok_type);
   assign accept    = tok_valid && tok_ready;
   assign wr_idx    = IDX_W'(sp_q);
   assign top_idx   = IDX_W'(sp_q - 1'b1);
   assign top_valid = (sp_q != '0);
   assign top_op    = opstk_q[top_idx];

   assign tok_ready    = (state_q == S_ACCEPT) || (state_q == S_ERR);
   assign busy         = (state_q != S_ACCEPT);
   assign result_valid = (state_q == S_CAPTURE);
   assign alu_opcode   = opc_q;
   assign alu_data     = data_q;
   assign result       = result_q;
   assign syntax_err   = syn_q;
   assign depth_err    = dep_q;
   assign overflow_err = ovf_q;

   // Next-state, stack bookkeeping and ALU opcode selection
   always_comb begin
      state_d  = state_q;
      pend_d   = pend_q;
      opc_d    = OPC_NOP;
      expect_d = expect_q;
      sp_d     = sp_q;
      occ_d    = occ_q;
      data_d   = data_q;
      result_d = result_q;
      syn_d    = syn_q;
      dep_d    = dep_q;
      ovf_d    = ovf_q;
      push_en  = 1'b0;
      push_val = ST_ADD;

      unique case (state_q)
         S_ACCEPT: begin
            if (accept) begin
               case (tok)
                  TOK_CLR: begin
                     opc_d    = OPC_CLR;
                     sp_d     = '0;
                     occ_d    = '0;
                     expect_d = 1'b1;
                     syn_d    = 1'b0;
                     dep_d    = 1'b0;
                     ovf_d    = 1'b0;
                  end
                  TOK_NUM: begin
                     if (!expect_q) begin
                        syn_d   = 1'b1;
                        state_d = S_ERR;
                     end else if (occ_q == OCC_FULL) begin
                        dep_d   = 1'b1;
                        state_d = S_ERR;
                     end else begin
                        opc_d    = OPC_PUSH;
                        data_d   = tok_data;
                        occ_d    = occ_q + 1'b1;
                        expect_d = 1'b0;
                     end
                  end
                  TOK_LPAR: begin
                     if (!expect_q) begin
                        syn_d   = 1'b1;
                        state_d = S_ERR;
                     end else if (sp_q == SP_FULL) begin
                        dep_d   = 1'b1;
                        state_d = S_ERR;
                     end else begin
                        push_en  = 1'b1;
                        push_val = ST_LPAR;
                        sp_d     = sp_q + 1'b1;
                     end
                  end
                  TOK_ADD, TOK_MUL, TOK_RPAR, TOK_EQ: begin
                     if (expect_q) begin
                        syn_d   = 1'b1;
                        state_d = S_ERR;
                     end else begin
                        pend_d  = tok;
                        state_d = S_DRAIN;
                        if ((tok == TOK_ADD) || (tok == TOK_MUL)) begin
                           expect_d = 1'b1;
                        end
                     end
                  end
                  default: begin
                     syn_d   = 1'b1;
                     state_d = S_ERR;
                  end
               endcase
            end
         end

         S_DRAIN: begin
            // One decision per cycle: pop one operator, push the pending one,
            // discard a matching '(', or finish.
            logic do_pop;
            do_pop = 1'b0;
            case (pend_q)
               TOK_MUL: do_pop = top_valid && (top_op == ST_MUL);
               TOK_ADD: do_pop = top_valid && (top_op != ST_LPAR);
               TOK_RPAR: begin
                  if (!top_valid) begin
                     syn_d   = 1'b1;
                     state_d = S_ERR;
                  end else if (top_op == ST_LPAR) begin
                     sp_d    = sp_q - 1'b1;
                     state_d = S_ACCEPT;
                  end else begin
                     do_pop = 1'b1;
                  end
               end
               default: begin
                  if (!top_valid) begin
                     state_d = S_CAPTURE;
                  end else if (top_op == ST_LPAR) begin
                     syn_d   = 1'b1;
                     state_d = S_ERR;
                  end else begin
                     do_pop = 1'b1;
                  end
               end
            endcase

            if (do_pop) begin
               opc_d = (top_op == ST_MUL) ? OPC_MUL : OPC_ADD;
               sp_d  = sp_q - 1'b1;
               if (occ_q != '0) begin
                  occ_d = occ_q - 1'b1;
               end
            end else if ((pend_q == TOK_ADD) || (pend_q == TOK_MUL)) begin
               if (sp_q == SP_FULL) begin
                  dep_d   = 1'b1;
                  state_d = S_ERR;
               end else begin
                  push_en  = 1'b1;
                  push_val = (pend_q == TOK_MUL) ? ST_MUL : ST_ADD;
                  sp_d     = sp_q + 1'b1;
                  state_d  = S_ACCEPT;
               end
            end
         end

         S_CAPTURE: begin
            result_d = alu_result;
            sp_d     = '0;
            occ_d    = '0;
            expect_d = 1'b1;
            opc_d    = OPC_CLR;
            state_d  = S_ACCEPT;
         end

         default: begin
            if (accept && (tok == TOK_CLR)) begin
               opc_d    = OPC_CLR;
               sp_d     = '0;
               occ_d    = '0;
               expect_d = 1'b1;
               syn_d    = 1'b0;
               dep_d    = 1'b0;
               ovf_d    = 1'b0;
               state_d  = S_ACCEPT;
            end
         end
      endcase

      // Overflow never aborts; it is only recorded.
      if (alu_overflow) begin
         ovf_d = 1'b1;
      end
   end

   // Control and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_ACCEPT;
         pend_q   <= TOK_ADD;
         opc_q    <= OPC_NOP;
         expect_q <= 1'b1;
         sp_q     <= '0;
         occ_q    <= '0;
         data_q   <= '0;
         result_q <= '0;
         syn_q    <= 1'b0;
         dep_q    <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         opc_q    <= opc_d;
         expect_q <= expect_d;
         sp_q     <= sp_d;
         occ_q    <= occ_d;
         data_q   <= data_d;
         result_q <= result_d;
         syn_q    <= syn_d;
         dep_q    <= dep_d;
         ovf_q    <= ovf_d;
      end
   end

   // Operator-stack storage; entries above sp_q are don't-care
   always_ff @(posedge clk) begin
      if (push_en) begin
         opstk_q[wr_idx] <= push_val;
      end
   end

endmodule

// File: doc/expr_sequencer.md
# expr_sequencer

Precedence-aware controller that sits between the token source (keypad/host decoder) and the stack-based ALU. It accepts an infix token stream over a valid/ready handshake and reorders it with an internal operator stack (shunting-yard). It issues exactly one ALU opcode per cycle and returns the final value on '='. It replaces ad-hoc per-operator sequencing with a single FSM that also owns error detection.

## Interface
- DATA_WIDTH, 8, operand/result width
- STACK_SIZE, 64, ALU operand-stack capacity, tracked for depth checking
- OP_DEPTH, 16, internal operator-stack entries
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- tok_valid  in  1  token present
- tok_ready  out  1  token accepted on an edge where tok_valid&&tok_ready
- tok_type  in  3  000 '+', 001 '*', 010 '(', 011 ')', 100 operand, 101 '=', 110 CLEAR, 111 reserved
- tok_data  in  DATA_WIDTH  operand value; meaningful only when tok_type is 100
- alu_opcode  out  3  000 NOP, 001 ALU_CLEAR, 100 ADD, 101 MUL, 110 PUSH; registered
- alu_data  out  DATA_WIDTH  PUSH value; registered
- alu_result  in  DATA_WIDTH  ALU top-of-stack, valid the cycle after an opcode
- alu_overflow  in  1  ALU arithmetic overflow flag
- result  out  DATA_WIDTH  last captured result
- result_valid  out  1  one-cycle pulse when result updates
- syntax_err  out  1  sticky; set by an illegal token sequence
- depth_err  out  1  sticky; set when the operator stack or ALU stack would exceed capacity
- overflow_err  out  1  sticky; set when alu_overflow is seen during an expression
- busy  out  1  high whenever the FSM state is not ACCEPT

## Operation
- States:
  - ACCEPT: tok_ready=1.
  - DRAIN: tok_ready=0. Holds a pending operator.
  - CAPTURE: tok_ready=0.
  - ERR: tok_ready=1. Every token except CLEAR is discarded.
- expect_operand flag:
  - Set at reset and after CLEAR, '(', '+' and '*'.
  - Cleared by an operand and by ')'.
- Legality, checked in ACCEPT:
  - operand and '(' require expect_operand=1.
  - '+', '*', ')' and '=' require expect_operand=0.
  - Reserved type is always illegal.
  - An illegal token sets syntax_err, drives alu_opcode=NOP and goes to ERR.
- Operand: alu_opcode<=PUSH, alu_data<=tok_data, occupancy+1. If occupancy==STACK_SIZE, set depth_err and go to ERR instead.
- '(': push an LPAREN marker onto the operator stack with no ALU op. A full operator stack sets depth_err and goes to ERR.
- '+' / '*' / ')' / '=': latch the token as pending, alu_opcode<=NOP, go to DRAIN.
- DRAIN, one decision per cycle, based on the operator-stack top:
  - Pending '*': pop while top is MUL.
  - Pending '+': pop while top is MUL or ADD.
  - Pending ')': pop while top is not LPAREN. At LPAREN, discard it and return to ACCEPT. An empty stack sets syntax_err and goes to ERR.
  - Pending '=': pop until the stack is empty, then go to CAPTURE. A popped LPAREN sets syntax_err and goes to ERR.
  - Each pop drives alu_opcode<=popped op and occupancy-1.
  - When no pop applies, '+'/'*' pushes the pending op (depth check as for '('), alu_opcode<=NOP, return to ACCEPT.
- CAPTURE, one cycle:
  - result<=alu_result, result_valid=1.
  - Clear the operator stack, occupancy and expect_operand (back to 1).
  - alu_opcode<=ALU_CLEAR. Go to ACCEPT.
- CLEAR, in ACCEPT or ERR:
  - alu_opcode<=ALU_CLEAR.
  - Empty all stacks and clear all three error flags.
  - result is unchanged. Go to ACCEPT.
- alu_overflow high in any cycle sets overflow_err. This does not abort: the result is still captured.

## Timing
- Reset values:
  - tok_ready=1, busy=0, alu_opcode=000, alu_data=0.
  - result=0, result_valid=0, all error flags 0.
  - State ACCEPT, stacks empty, occupancy 0, expect_operand=1.
- An accepted operand puts PUSH on alu_opcode the next cycle. Back-to-back acceptance is sustained (tok_ready stays 1).
- '+'/'*' with no pops costs 1 DRAIN cycle, so tok_ready is low for 1 cycle. Each pop adds 1 cycle.
- ')' costs 1 DRAIN cycle plus 1 per pop.
- '=' takes N pops + 1 DRAIN cycle + 1 CAPTURE cycle. result_valid is asserted in the CAPTURE cycle, and result holds the value from the next edge.
- Reset asserted mid-DRAIN or mid-CAPTURE forces reset values immediately. The ALU is not told; the source must send CLEAR after reset.

## Test plan
- 2 + 3 * 4 = -> alu_opcode sequence PUSH2, NOP, PUSH3, NOP, PUSH4, MUL, ADD, then CAPTURE; result=14, result_valid for 1 cycle.
- ( 2 + 3 ) * 4 = -> PUSH2, PUSH3, ADD on ')', then MUL on '='; result=20.
- 2 * 3 + 4 = -> the '+' DRAIN emits MUL before pushing ADD, holding tok_ready low 2 cycles; result=10.
- '+' as first token -> syntax_err=1, state ERR, later tokens produce NOP; CLEAR -> ALU_CLEAR, syntax_err=0, tok_ready=1.
- 2 ) and ( 2 = -> each sets syntax_err; 17 nested '(' with OP_DEPTH=16 -> depth_err.
- 200 * 2 = with alu_overflow pulsed during MUL -> overflow_err=1 and result captured. rst_n low during a 3-pop DRAIN -> all outputs at reset values that cycle.
